seq_inequality: RTL

Parametrised, clocked successor to the combinational inequality block. Compares two WIDTH-bit operands one bit per cycle, MSB first, in unsigned or two's-complement mode, and reports a one-hot {GT, EQ, LT} result. A START/BUSY/DONE handshake lets a controller launch comparisons and collect held results. It sits between operand registers and any sequencer that needs a magnitude decision without a WIDTH-wide comparator.

---
 rtl/seq_inequality_pkg.sv | 31 +++
 rtl/seq_inequality_bit_cell.sv | 19 +
 rtl/seq_inequality.sv | 118 +++++++++++
 3 files changed

// File: rtl/seq_inequality_pkg.sv
// rtl/seq_inequality_pkg.sv - shared types, result bit positions and bit-decision helper for seq_inequality
package seq_inequality_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam int OUT_GT = 2;
    localparam int OUT_EQ = 1;
    localparam int OUT_LT = 0;

    // At the sign bit of a signed compare the operand holding a 1 is the smaller one.
    function automatic logic [2:0] ineq_code(
        input logic differ,
        input logic a_bit,
        input logic is_msb,
        input logic is_signed
    );
        logic [2:0] code;
        code = 3'b000;
        if (!differ)
            code[OUT_EQ] = 1'b1;
        else if (a_bit ^ (is_msb & is_signed))
            code[OUT_GT] = 1'b1;
        else
            code[OUT_LT] = 1'b1;
        return code;
    endfunction

endpackage

// File: rtl/seq_inequality_bit_cell.sv
// rtl/seq_inequality_bit_cell.sv - combinational single-bit compare with sign-bit handling
module ineq_bit_cell
    import seq_inequality_pkg::*;
(
    input  logic       i_a_bit,
    input  logic       i_b_bit,
    input  logic       i_is_msb,
    input  logic       i_signed,
    output logic       o_differ,
    output logic [2:0] o_code
);

    logic w_differ;

    assign w_differ = i_a_bit ^ i_b_bit;
    assign o_differ = w_differ;
    assign o_code   = ineq_code(w_differ, i_a_bit, i_is_msb, i_signed);

endmodule

// File: rtl/seq_inequality.sv
// rtl/seq_inequality.sv - bit-serial MSB-first magnitude compare with start/busy/done handshake
module seq_inequality
    import seq_inequality_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [WIDTH-1:0]           i_a,
    input  logic [WIDTH-1:0]           i_b,
    input  logic                       i_signed,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [2:0]                 o_out,
    output logic [$clog2(WIDTH+1)-1:0] o_cycles
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_cnt;
    logic             r_found;
    logic [2:0]       r_dec;
    logic             r_busy;
    logic             r_done;
    logic [2:0]       r_out;
    logic [CW-1:0]    r_cycles;

    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_is_msb;
    logic             w_differ;
    logic [2:0]       w_code;
    logic [2:0]       w_result;
    logic [CW-1:0]    w_cnt_next;
    logic             w_finish;

    assign w_a_bit    = r_a[r_idx];
    assign w_b_bit    = r_b[r_idx];
    assign w_is_msb   = (r_idx == IW'(WIDTH - 1));
    assign w_cnt_next = r_cnt + CW'(1);

    ineq_bit_cell u_cell (
        .i_a_bit  (w_a_bit),
        .i_b_bit  (w_b_bit),
        .i_is_msb (w_is_msb),
        .i_signed (r_signed),
        .o_differ (w_differ),
        .o_code   (w_code)
    );

    // Without early exit the first difference wins; later bits only keep the scan running.
    assign w_result = r_found ? r_dec : w_code;
    assign w_finish = (EARLY_EXIT && w_differ) || (r_idx == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_found  <= 1'b0;
            r_dec    <= 3'b000;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_out    <= 3'b000;
            r_cycles <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a      <= i_a;
                        r_b      <= i_b;
                        r_signed <= i_signed;
                        r_idx    <= IW'(WIDTH - 1);
                        r_cnt    <= '0;
                        r_found  <= 1'b0;
                        r_dec    <= 3'b000;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    r_cnt <= w_cnt_next;
                    r_idx <= r_idx - 1'b1;
                    if (w_differ && !r_found) begin
                        r_found <= 1'b1;
                        r_dec   <= w_code;
                    end
                    if (w_finish) begin
                        r_out    <= w_result;
                        r_cycles <= w_cnt_next;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_out    = r_out;
    assign o_cycles = r_cycles;

endmodule
